// File: rtl/mod4_arbiter.sv
// mod4_arbiter: two-requester round-robin arbiter and sequencer for a shared
// combinational mod4 unit. It grants one requester, drives that operand into
// the unit, captures the result one cycle later and offers it with the
// owner's ID on a valid/ready result port.
module mod4_arbiter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         REQ0,
   input  logic [W-1:0] A0,
   output logic         ACK0,
   input  logic         REQ1,
   input  logic [W-1:0] A1,
   output logic         ACK1,
   output logic [W-1:0] DP_A,
   input  logic [W-1:0] DP_OUT,
   output logic         RES_VALID,
   output logic [W-1:0] RES_OUT,
   output logic         RES_ID,
   input  logic         RES_READY,
   output logic         BUSY
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t state;
   logic   last;
   logic   grant;
   logic   any_req;

   // Round-robin pick: a lone requester wins, a contested grant goes to the
   // requester that was not served last.
   always_comb begin
      any_req = REQ0 | REQ1;
      grant   = 1'b0;
      if (REQ0 && REQ1) begin
         grant = ~last;
      end else begin
         grant = REQ1;
      end
   end

   // Sequencer: IDLE grants and launches the operand, EVAL captures the
   // mod4 result after a full settle cycle, HOLD waits for the consumer.
   // Requests are only looked at in IDLE, so a grant can never coincide
   // with the result handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= 1'b1;
         DP_A      <= '0;
         ACK0      <= 1'b0;
         ACK1      <= 1'b0;
         RES_VALID <= 1'b0;
         RES_OUT   <= '0;
         RES_ID    <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  DP_A   <= grant ? A1 : A0;
                  RES_ID <= grant;
                  ACK0   <= ~grant;
                  ACK1   <= grant;
                  last   <= grant;
                  BUSY   <= 1'b1;
                  state  <= EVAL;
               end
            end
            EVAL: begin
               RES_OUT   <= DP_OUT;
               RES_VALID <= 1'b1;
               ACK0      <= 1'b0;
               ACK1      <= 1'b0;
               state     <= HOLD;
            end
            HOLD: begin
               if (RES_READY) begin
                  RES_VALID <= 1'b0;
                  BUSY      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               RES_VALID <= 1'b0;
               ACK0      <= 1'b0;
               ACK1      <= 1'b0;
               BUSY      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod4_arbiter.sv
// tb_mod4_arbiter: self-checking bench for mod4_arbiter. A behavioural mod4
// unit closes the datapath loop; a transaction-level reference model
// predicts every output each cycle from the arbitration rules.
module tb_mod4_arbiter;

   logic       clk;
   logic       rst;
   logic       req0, req1;
   logic [3:0] a0, a1;
   logic       ack0, ack1;
   logic [3:0] dpA;
   logic [3:0] dpOut;
   logic       resValid;
   logic [3:0] resOut;
   logic       resId;
   logic       resReady;
   logic       busy;

   int checks = 0;
   int fails  = 0;

   // requester intent and operands
   logic       want0 = 1'b0, want1 = 1'b0;
   logic [3:0] op0 = '0, op1 = '0;
   int         grantLog[$];

   // reference model state
   int         mPhase = 0;
   logic       mLast = 1'b1;
   logic       mAck0 = 1'b0, mAck1 = 1'b0;
   logic [3:0] mDpa = '0, mOut = '0;
   logic       mValid = 1'b0, mId = 1'b0, mBusy = 1'b0;

   mod4_arbiter #(.W(4)) dut (
      .clk(clk), .rst(rst),
      .REQ0(req0), .A0(a0), .ACK0(ack0),
      .REQ1(req1), .A1(a1), .ACK1(ack1),
      .DP_A(dpA), .DP_OUT(dpOut),
      .RES_VALID(resValid), .RES_OUT(resOut), .RES_ID(resId),
      .RES_READY(resReady), .BUSY(busy)
   );

   // behavioural mod4 unit
   assign dpOut = 4'(dpA % 4'd4);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance the reference model across one edge using the values driven.
   task automatic modelStep(input logic r, input logic rdy);
      int g;
      if (r) begin
         mPhase = 0; mLast = 1'b1; mAck0 = 1'b0; mAck1 = 1'b0;
         mDpa = '0; mValid = 1'b0; mOut = '0; mId = 1'b0; mBusy = 1'b0;
      end else if (mPhase == 0) begin
         if (want0 || want1) begin
            if (want0 && want1) g = (mLast == 1'b1) ? 0 : 1;
            else                g = want1 ? 1 : 0;
            mDpa  = (g == 1) ? op1 : op0;
            mId   = (g == 1);
            mAck0 = (g == 0);
            mAck1 = (g == 1);
            mLast = (g == 1);
            mBusy = 1'b1;
            mPhase = 1;
         end
      end else if (mPhase == 1) begin
         mOut   = 4'(mDpa % 4'd4);
         mValid = 1'b1;
         mAck0  = 1'b0;
         mAck1  = 1'b0;
         mPhase = 2;
      end else begin
         if (rdy) begin
            mValid = 1'b0;
            mBusy  = 1'b0;
            mPhase = 0;
         end
      end
   endtask

   // One clock: drive inputs, predict, sample at the falling edge, compare,
   // then apply the requester protocol (drop REQ once ACK is seen).
   task automatic applyStimulus(input logic r, input logic rdy);
      rst      = r;
      req0     = want0;
      a0       = op0;
      req1     = want1;
      a1       = op1;
      resReady = rdy;
      modelStep(r, rdy);
      @(posedge clk);
      @(negedge clk);
      checkOutput("ack0", ack0, mAck0);
      checkOutput("ack1", ack1, mAck1);
      checkOutput("dp_a", dpA, mDpa);
      checkOutput("res_valid", resValid, mValid);
      checkOutput("res_out", resOut, mOut);
      checkOutput("res_id", resId, mId);
      checkOutput("busy", busy, mBusy);
      if (ack0 === 1'b1) begin want0 = 1'b0; grantLog.push_back(0); end
      if (ack1 === 1'b1) begin want1 = 1'b0; grantLog.push_back(1); end
   endtask

   initial begin
      logic [3:0] heldDpa;
      logic [3:0] vals [4];
      bit done;

      // reset with REQ0 held, then the single-request transaction
      want0 = 1'b1; op0 = 4'b0110;
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1);
      checkOutput("rst_ack0", ack0, 0);
      checkOutput("rst_dpa", dpA, 0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("single_ack0", ack0, 1);
      checkOutput("single_dpa", dpA, 4'b0110);
      applyStimulus(1'b0, 1'b1);
      checkOutput("single_valid", resValid, 1);
      checkOutput("single_out", resOut, 4'b0010);
      checkOutput("single_id", resId, 0);
      applyStimulus(1'b0, 1'b1);

      // contention: fresh reset so requester 0 wins first
      applyStimulus(1'b1, 1'b1);
      grantLog.delete();
      want0 = 1'b1; want1 = 1'b1; op0 = 4'b0111; op1 = 4'b0101;
      for (int c = 0; c < 40 && grantLog.size() < 4; c++) begin
         applyStimulus(1'b0, 1'b1);
         if (resValid === 1'b1) begin
            if (resId === 1'b0) want0 = 1'b1;
            else                want1 = 1'b1;
         end
      end
      checkOutput("cont_grants", grantLog.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < grantLog.size()) checkOutput("cont_order", grantLog[i], i % 2);
      end
      want0 = 1'b0; want1 = 1'b0;
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1);

      // backpressure in HOLD with REQ1 waiting
      want0 = 1'b1; op0 = 4'h9;
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         applyStimulus(1'b0, 1'b0);
         if (resValid === 1'b1) done = 1'b1;
      end
      checkOutput("bp_reach_hold", done, 1);
      want1 = 1'b1; op1 = 4'hE;
      heldDpa = dpA;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b0, 1'b0);
         checkOutput("bp_no_ack1", ack1, 0);
         checkOutput("bp_dpa_stable", dpA, heldDpa);
         checkOutput("bp_out_stable", resOut, 4'h1);
      end
      applyStimulus(1'b0, 1'b1);
      checkOutput("bp_idle_no_ack1", ack1, 0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("bp_ack1", ack1, 1);
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1);

      // reset while in EVAL
      want0 = 1'b1; op0 = 4'hB;
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         applyStimulus(1'b0, 1'b1);
         if (ack0 === 1'b1) done = 1'b1;
      end
      checkOutput("reval_ack0", done, 1);
      applyStimulus(1'b1, 1'b1);
      checkOutput("reval_busy", busy, 0);
      checkOutput("reval_dpa", dpA, 0);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 1'b1);
         checkOutput("reval_no_valid", resValid, 0);
      end

      // exhaustive operand sweep on requester 0
      for (int v = 0; v < 16; v++) begin
         want0 = 1'b1; op0 = 4'(v);
         done = 1'b0;
         for (int c = 0; c < 10 && !done; c++) begin
            applyStimulus(1'b0, 1'b1);
            if (resValid === 1'b1) begin
               done = 1'b1;
               checkOutput("sweep_out", resOut, v % 4);
               checkOutput("sweep_id", resId, 0);
            end
         end
         checkOutput("sweep_done", done, 1);
         applyStimulus(1'b0, 1'b1);
      end

      // randomized traffic with backpressure and occasional reset
      for (int c = 0; c < 600; c++) begin
         if (!want0 && $urandom_range(0, 2) == 0) begin
            want0 = 1'b1; op0 = 4'($urandom_range(0, 15));
         end
         if (!want1 && $urandom_range(0, 2) == 0) begin
            want1 = 1'b1; op1 = 4'($urandom_range(0, 15));
         end
         vals[0] = 4'($urandom_range(0, 3));
         applyStimulus($urandom_range(0, 59) == 0, vals[0] != 4'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
